psr_branch_unit: RTL and testbench

- Consumer side of the ALU flag interface.
- Holds the architectural PSR (C F L Z N), applies per-bit masked flag updates from the ALU, and evaluates Bcond/Jcond requests from the controller against it.
- Returns a registered taken/not-taken decision plus the next-PC target over a req/valid handshake.
- Sits between the ALU and the PC/fetch logic.

---
 rtl/psr_branch_unit.sv | 180 ++++++++++++++++++
 tb/tb_psr_branch_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/psr_branch_unit.sv
// psr_branch_unit: holds the architectural PSR (C F L Z N), applies masked
// flag writes from the ALU, and resolves Bcond/Jcond requests into a
// taken/not-taken decision plus next-PC target two cycles after the request.
// Optional macro BRANCH_STATS_EN adds saturating taken/total counters;
// without it the counter ports are tied to zero.
module psr_branch_unit #(
    parameter int WIDTH  = 16,
    parameter int DISP_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [4:0]        psr_in,
    input  logic [4:0]        flag_we,
    input  logic              br_req,
    input  logic              br_is_jump,
    input  logic [3:0]        cond,
    input  logic [WIDTH-1:0]  pc,
    input  logic [DISP_W-1:0] disp,
    input  logic [WIDTH-1:0]  jtarget,
    output logic [4:0]        psr_out,
    output logic              br_busy,
    output logic              br_valid,
    output logic              br_taken,
    output logic [WIDTH-1:0]  br_target,
    output logic [15:0]       taken_cnt,
    output logic [15:0]       total_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [4:0]        psr, psr_nxt;
    logic [4:0]        snap;
    logic [3:0]        cap_cond;
    logic              cap_jump;
    logic [WIDTH-1:0]  cap_pc;
    logic [DISP_W-1:0] cap_disp;
    logic [WIDTH-1:0]  cap_jt;
    logic              eval_taken;
    logic [WIDTH-1:0]  eval_target;
    logic              capture;

    // Flag bit positions inside the PSR
    localparam int FC = 0;
    localparam int FF = 1;
    localparam int FL = 2;
    localparam int FZ = 3;
    localparam int FN = 4;

    // Condition evaluation against a flag snapshot
    function automatic logic cond_met(input logic [3:0] c, input logic [4:0] f);
        logic r;
        case (c)
            4'h0:    r = f[FZ];
            4'h1:    r = !f[FZ];
            4'h2:    r = f[FC];
            4'h3:    r = !f[FC];
            4'h4:    r = f[FL];
            4'h5:    r = !f[FL];
            4'h6:    r = f[FN];
            4'h7:    r = !f[FN];
            4'h8:    r = f[FF];
            4'h9:    r = !f[FF];
            4'hA:    r = !f[FL] && !f[FZ];
            4'hB:    r = f[FL] || f[FZ];
            4'hC:    r = !f[FN] && !f[FZ];
            4'hD:    r = f[FN] || f[FZ];
            4'hE:    r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Post-write PSR value; also feeds the snapshot so a same-cycle compare is visible
    assign psr_nxt = (psr & ~flag_we) | (psr_in & flag_we);
    assign psr_out = psr;
    assign capture = (state == IDLE) && br_req;

    // Decision and target computed from the captured request
    always_comb begin
        eval_taken  = cond_met(cap_cond, snap);
        eval_target = cap_pc + WIDTH'(1);
        if (eval_taken) begin
            if (cap_jump)
                eval_target = cap_jt;
            else
                eval_target = cap_pc + {{(WIDTH-DISP_W){cap_disp[DISP_W-1]}}, cap_disp};
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        br_busy   = 1'b0;
        br_valid  = 1'b0;
        case (state)
            IDLE: if (br_req) state_nxt = EVAL;
            EVAL: begin
                br_busy   = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                br_busy   = 1'b1;
                br_valid  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // PSR register: masked writes accepted in every state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) psr <= '0;
        else          psr <= psr_nxt;
    end

    // Request capture in IDLE; later flag writes do not disturb the snapshot
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap     <= '0;
            cap_cond <= '0;
            cap_jump <= 1'b0;
            cap_pc   <= '0;
            cap_disp <= '0;
            cap_jt   <= '0;
        end else if (capture) begin
            snap     <= psr_nxt;
            cap_cond <= cond;
            cap_jump <= br_is_jump;
            cap_pc   <= pc;
            cap_disp <= disp;
            cap_jt   <= jtarget;
        end
    end

    // Result registers load at the end of EVAL and hold until the next one
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            br_taken  <= 1'b0;
            br_target <= '0;
        end else if (state == EVAL) begin
            br_taken  <= eval_taken;
            br_target <= eval_target;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [15:0] taken_q, total_q;

    // Saturating statistics, bumped once per response
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            taken_q <= '0;
            total_q <= '0;
        end else if (state == RESP) begin
            if (total_q != 16'hFFFF)
                total_q <= total_q + 16'd1;
            if (br_taken && taken_q != 16'hFFFF)
                taken_q <= taken_q + 16'd1;
        end
    end

    assign taken_cnt = taken_q;
    assign total_cnt = total_q;
`else
    assign taken_cnt = '0;
    assign total_cnt = '0;
`endif

endmodule

// File: tb/tb_psr_branch_unit.sv
// Scoreboard bench for psr_branch_unit: stimulus pushes expected responses,
// a negedge monitor compares PSR, busy, counters and every br_valid response.
module tb_psr_branch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  psr_in, flag_we;
    logic        br_req, br_is_jump;
    logic [3:0]  cond;
    logic [15:0] pc, jtarget;
    logic [7:0]  disp;
    logic [4:0]  psr_out;
    logic        br_busy, br_valid, br_taken;
    logic [15:0] br_target, taken_cnt, total_cnt;

    psr_branch_unit #(.WIDTH(16), .DISP_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .psr_in(psr_in), .flag_we(flag_we),
        .br_req(br_req), .br_is_jump(br_is_jump), .cond(cond), .pc(pc),
        .disp(disp), .jtarget(jtarget), .psr_out(psr_out), .br_busy(br_busy),
        .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target),
        .taken_cnt(taken_cnt), .total_cnt(total_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        taken;
        logic [15:0] target;
    } resp_t;

    resp_t       exp_q[$];
    int          cyc = 0;
    int          last_acc = -100;
    logic [4:0]  psr_vis = '0;
    logic [4:0]  psr_pend = '0;
    logic        started = 1'b0;
    int          n_pass = 0, n_total = 0;
    int          mon_taken = 0, mon_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got 0x%0h want 0x%0h", name, cyc, act, exp);
    endtask

    // Reference: the branch condition table in terms of named flags
    function automatic logic ref_cond(input logic [3:0] c, input logic [4:0] f);
        logic cf, ff, lf, zf, nf;
        {nf, zf, lf, ff, cf} = f;
        case (c)
            4'd0:  return zf;
            4'd1:  return !zf;
            4'd2:  return cf;
            4'd3:  return !cf;
            4'd4:  return lf;
            4'd5:  return !lf;
            4'd6:  return nf;
            4'd7:  return !nf;
            4'd8:  return ff;
            4'd9:  return !ff;
            4'd10: return !(lf || zf);
            4'd11: return lf || zf;
            4'd12: return !(nf || zf);
            4'd13: return nf || zf;
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic model_busy(input int k);
        return (k > last_acc) && (k <= last_acc + 2);
    endfunction

    // One clock of stimulus plus the reference model update
    task automatic step(input logic [4:0] we, input logic [4:0] pin, input logic req,
                        input logic jump, input logic [3:0] c, input logic [15:0] p,
                        input logic [7:0] d, input logic [15:0] jt);
        resp_t r;
        int    sd, t;
        @(posedge clk); #1;
        cyc++;
        psr_vis  = psr_pend;
        flag_we  = we;   psr_in = pin;  br_req = req; br_is_jump = jump;
        cond     = c;    pc = p;        disp = d;     jtarget = jt;
        psr_pend = (psr_vis & ~we) | (pin & we);
        if (req && !model_busy(cyc)) begin
            r.cyc   = cyc + 2;
            r.taken = ref_cond(c, psr_pend);
            sd      = d[7] ? int'(d) - 256 : int'(d);
            if (!r.taken)  t = int'(p) + 1;
            else if (jump) t = int'(jt);
            else           t = int'(p) + sd;
            r.target = 16'(t & 16'hFFFF);
            exp_q.push_back(r);
            last_acc = cyc;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(5'h0, 5'h0, 1'b0, 1'b0, 4'h0, 16'h0, 8'h0, 16'h0);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            cyc++;
            reset_n = (i == 2);
            flag_we = '0; psr_in = '0; br_req = 1'b0; br_is_jump = 1'b0;
            cond = '0; pc = '0; disp = '0; jtarget = '0;
            psr_vis = '0; psr_pend = '0; last_acc = -100;
            exp_q.delete();
        end
    endtask

    // Monitor: compares visible state every cycle and pops on br_valid
    always @(negedge clk) begin
        if (started) begin
            chk("psr_out", 32'(psr_out), 32'(psr_vis));
            chk("br_busy", 32'(br_busy), 32'(model_busy(cyc)));
`ifdef BRANCH_STATS_EN
            chk("taken_cnt", 32'(taken_cnt), 32'(mon_taken));
            chk("total_cnt", 32'(total_cnt), 32'(mon_total));
`else
            chk("taken_cnt", 32'(taken_cnt), 32'd0);
            chk("total_cnt", 32'(total_cnt), 32'd0);
`endif
            if (!reset_n) begin
                chk("br_valid_in_reset", 32'(br_valid), 32'd0);
                mon_taken = 0; mon_total = 0;
            end else begin
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    chk("missing_br_valid", 32'(exp_q[0].cyc), 32'(cyc));
                    void'(exp_q.pop_front());
                end
                if (br_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_br_valid", 32'(br_valid), 32'd0);
                    end else begin
                        chk("valid_cycle", 32'(cyc), 32'(exp_q[0].cyc));
                        chk("br_taken", 32'(br_taken), 32'(exp_q[0].taken));
                        chk("br_target", 32'(br_target), 32'(exp_q[0].target));
                        if (mon_total < 16'hFFFF) mon_total++;
                        if (exp_q[0].taken && mon_taken < 16'hFFFF) mon_taken++;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        flag_we = '0; psr_in = '0; br_req = 1'b0; br_is_jump = 1'b0;
        cond = '0; pc = '0; disp = '0; jtarget = '0;
        do_reset();
        started = 1'b1;
        idle(2);

        // Masked write: Z then C, each leaving the other bit alone
        step(5'b01000, 5'b01000, 0, 0, 4'h0, 16'h0, 8'h0, 16'h0);
        step(5'b00001, 5'b00001, 0, 0, 4'h0, 16'h0, 8'h0, 16'h0);
        idle(1);
        chk("masked_write", 32'(psr_out), 32'h09);

        // Bypass: set Z in the same cycle as an EQ branch, pc 0x10 disp -2 -> 0x0E
        step(5'h1F, 5'h00, 0, 0, 4'h0, 16'h0, 8'h0, 16'h0);
        step(5'h08, 5'h08, 1, 0, 4'h0, 16'h0010, 8'hFE, 16'h0);
        idle(3);

        // Not-taken wrap: Z=0, EQ at 0xFFFF -> 0x0000
        step(5'h08, 5'h00, 1, 0, 4'h0, 16'hFFFF, 8'h10, 16'h0);
        idle(3);
        // Never condition with every flag set
        step(5'h1F, 5'h1F, 1, 0, 4'hF, 16'h0100, 8'h05, 16'h0);
        idle(3);

        // Jump then a dropped request one cycle later; flags change mid-flight
        step(5'h00, 5'h00, 1, 1, 4'hE, 16'h0200, 8'h00, 16'h1234);
        step(5'h1F, 5'h00, 1, 1, 4'hE, 16'h0300, 8'h00, 16'h5678);
        idle(5);

        // Counter pattern: 3 taken (UC) and 2 not taken (never)
        for (int i = 0; i < 5; i++) begin
            step(5'h00, 5'h00, 1, 0, (i < 3) ? 4'hE : 4'hF, 16'(16'h0400 + i), 8'h7F, 16'h0);
            idle(2);
        end
        idle(1);
`ifdef BRANCH_STATS_EN
        chk("stats_taken", 32'(taken_cnt), 32'd3);
        chk("stats_total", 32'(total_cnt), 32'd5);
`else
        chk("stats_taken_off", 32'(taken_cnt), 32'd0);
        chk("stats_total_off", 32'(total_cnt), 32'd0);
`endif

        // Randomized traffic: random masks, flags, conditions and targets
        for (int i = 0; i < 400; i++) begin
            step(5'($urandom), 5'($urandom), ($urandom_range(0, 2) == 0),
                 1'($urandom), 4'($urandom), 16'($urandom), 8'($urandom), 16'($urandom));
        end
        idle(4);

        // Reset in the middle of EVAL: request must vanish
        step(5'h1F, 5'h1F, 1, 0, 4'hE, 16'h0040, 8'h04, 16'h0);
        step(5'h00, 5'h00, 0, 0, 4'h0, 16'h0, 8'h0, 16'h0);
        @(negedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("async_reset_psr", 32'(psr_out), 32'd0);
        chk("async_reset_busy", 32'(br_busy), 32'd0);
        do_reset();
        idle(6);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
